// File: rtl/layer_1_5_multiply_pkg.sv
// Shared widths and lane count for the layer-1 five-lane masked multiply-accumulate.
// Contents: default weight width, integer bits, accumulator width, lane count.
// Imported by the interface, the lane sub-module and the top level.
package layer_1_5_multiply_pkg;
  localparam int WEIGHT_SIZE = 8;   // signed weight width
  localparam int SIGN_BITS   = 4;   // integer bits of a weight, sign included
  localparam int ACC_SIZE    = 16;  // signed accumulator / output width
  localparam int NUM_LANES   = 5;   // neurons handled by one instance
endpackage

// File: rtl/layer_1_5_multiply_if.sv
// Bus bundle between the layer-1 controller and one five-lane multiply-accumulate block.
// master: drives weights, mask, load, accumulate; samples sums and accumulate_signal.
// slave : the accumulate block, consuming the controls and driving the registered sums.
interface layer_1_5_multiply_if
  import layer_1_5_multiply_pkg::*;
#(
  parameter int SIZE        = WEIGHT_SIZE,
  parameter int OUTPUT_SIZE = ACC_SIZE
);
  logic signed [SIZE-1:0]        vector_input_1;
  logic signed [SIZE-1:0]        vector_input_2;
  logic signed [SIZE-1:0]        vector_input_3;
  logic signed [SIZE-1:0]        vector_input_4;
  logic signed [SIZE-1:0]        vector_input_5;
  logic                          mask_input;
  logic                          load;
  logic                          accumulate;
  logic signed [OUTPUT_SIZE-1:0] accumulate_1;
  logic signed [OUTPUT_SIZE-1:0] accumulate_2;
  logic signed [OUTPUT_SIZE-1:0] accumulate_3;
  logic signed [OUTPUT_SIZE-1:0] accumulate_4;
  logic signed [OUTPUT_SIZE-1:0] accumulate_5;
  logic                          accumulate_signal;

  modport master (
    output vector_input_1, vector_input_2, vector_input_3, vector_input_4, vector_input_5,
    output mask_input, load, accumulate,
    input  accumulate_1, accumulate_2, accumulate_3, accumulate_4, accumulate_5,
    input  accumulate_signal
  );

  modport slave (
    input  vector_input_1, vector_input_2, vector_input_3, vector_input_4, vector_input_5,
    input  mask_input, load, accumulate,
    output accumulate_1, accumulate_2, accumulate_3, accumulate_4, accumulate_5,
    output accumulate_signal
  );
endinterface

// File: rtl/layer_1_5_multiply_lane.sv
// One lane: registers the masked, sign-extended weight, then adds it into a running sum.
// Ports: clk/reset, weight_i, mask_i, load_i, shared stage_valid_i/stage_first_i, acc_o.
// Latency: weight sampled at edge k is in acc_o after edge k+1; no backpressure.
module masked_accumulate_lane
  import layer_1_5_multiply_pkg::*;
#(
  parameter int SIZE        = WEIGHT_SIZE,
  parameter int OUTPUT_SIZE = ACC_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [SIZE-1:0]        weight_i,
  input  logic                          mask_i,
  input  logic                          load_i,
  input  logic                          stage_valid_i,
  input  logic                          stage_first_i,
  output logic signed [OUTPUT_SIZE-1:0] acc_o
);
  logic signed [OUTPUT_SIZE-1:0] prod_q, prod_d;
  logic signed [OUTPUT_SIZE-1:0] acc_q, acc_d;

  always_comb begin
    // A mask bit of 1 passes the weight; the signed cast sign-extends it.
    prod_d = '0;
    if (load_i && mask_i) prod_d = OUTPUT_SIZE'(weight_i);

    // First product of a run replaces the old sum instead of adding to it.
    acc_d = acc_q;
    if (stage_valid_i) acc_d = (stage_first_i ? '0 : acc_q) + prod_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/layer_1_5_multiply.sv
// Five-lane bit-serial masked multiply-accumulate for layer 1 (one shared pixel bit per cycle).
// Ports: clk, reset (async active-low), bus (slave modport: weights, mask, load, accumulate, sums).
// Latency: two stages, inputs at edge k land in the sums after edge k+1; no backpressure.
module layer_1_5_multiply
  import layer_1_5_multiply_pkg::*;
#(
  parameter int SIZE          = WEIGHT_SIZE,
  parameter int SIGN_BIT_SIZE = SIGN_BITS,
  parameter int OUTPUT_SIZE   = ACC_SIZE
) (
  input logic                 clk,
  input logic                 reset,
  layer_1_5_multiply_if.slave bus
);
  // Widths must leave room for sign extension and a non-negative fraction part.
  if (OUTPUT_SIZE < SIZE || SIGN_BIT_SIZE > SIZE) begin : g_bad_widths
    $error("layer_1_5_multiply: inconsistent width parameters");
  end

  logic stage_valid_q, stage_valid_d;
  logic stage_first_q, stage_first_d;
  logic acc_signal_q,  acc_signal_d;

  logic signed [SIZE-1:0]        weight [NUM_LANES];
  logic signed [OUTPUT_SIZE-1:0] acc    [NUM_LANES];

  assign weight[0] = bus.vector_input_1;
  assign weight[1] = bus.vector_input_2;
  assign weight[2] = bus.vector_input_3;
  assign weight[3] = bus.vector_input_4;
  assign weight[4] = bus.vector_input_5;

  always_comb begin
    stage_valid_d = bus.accumulate;
    // Rising edge of accumulate (relative to the stage register) opens a new run.
    stage_first_d = bus.accumulate & ~stage_valid_q;
    acc_signal_d  = stage_valid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_q <= 1'b0;
      stage_first_q <= 1'b0;
      acc_signal_q  <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_first_q <= stage_first_d;
      acc_signal_q  <= acc_signal_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    masked_accumulate_lane #(
      .SIZE        (SIZE),
      .OUTPUT_SIZE (OUTPUT_SIZE)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .weight_i      (weight[g]),
      .mask_i        (bus.mask_input),
      .load_i        (bus.load),
      .stage_valid_i (stage_valid_q),
      .stage_first_i (stage_first_q),
      .acc_o         (acc[g])
    );
  end

  assign bus.accumulate_1      = acc[0];
  assign bus.accumulate_2      = acc[1];
  assign bus.accumulate_3      = acc[2];
  assign bus.accumulate_4      = acc[3];
  assign bus.accumulate_5      = acc[4];
  assign bus.accumulate_signal = acc_signal_q;
endmodule

// File: tb/tb_layer_1_5_multiply.sv
// Directed bench for layer_1_5_multiply: reset, basic run, masking, restart, full length, mid-run reset.
// Drives inputs and samples outputs 1 time unit after each rising edge.
// Expected sums are hand-computed constants.
module tb_layer_1_5_multiply;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  layer_1_5_multiply_if #(.SIZE(8), .OUTPUT_SIZE(16)) bus ();

  layer_1_5_multiply dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d, input int e);
    bus.vector_input_1 = 8'(a);
    bus.vector_input_2 = 8'(b);
    bus.vector_input_3 = 8'(c);
    bus.vector_input_4 = 8'(d);
    bus.vector_input_5 = 8'(e);
  endtask

  task automatic chk_lanes(input string tag, input int e1, input int e2, input int e3,
                           input int e4, input int e5);
    chk({tag, "_1"}, int'(bus.accumulate_1), e1);
    chk({tag, "_2"}, int'(bus.accumulate_2), e2);
    chk({tag, "_3"}, int'(bus.accumulate_3), e3);
    chk({tag, "_4"}, int'(bus.accumulate_4), e4);
    chk({tag, "_5"}, int'(bus.accumulate_5), e5);
  endtask

  // n accumulate cycles with mask bit i taken from mpat[i], then the two-edge drain.
  task automatic run(input string tag, input int n, input logic [255:0] mpat,
                     input int e1, input int e2, input int e3, input int e4, input int e5);
    int hi;
    hi = 0;
    bus.load       = 1'b1;
    bus.accumulate = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mask_input = mpat[i];
      step();
      if (i == 0) chk({tag, "_sig_delay"}, int'(bus.accumulate_signal), 0);
      hi += int'(bus.accumulate_signal);
    end
    bus.accumulate = 1'b0;
    bus.load       = 1'b0;
    bus.mask_input = 1'b0;
    step();
    hi += int'(bus.accumulate_signal);
    chk({tag, "_sig_last_add"}, int'(bus.accumulate_signal), 1);
    step();
    hi += int'(bus.accumulate_signal);
    chk({tag, "_sig_fall"}, int'(bus.accumulate_signal), 0);
    chk({tag, "_sig_cycles"}, hi, n);
    chk_lanes(tag, e1, e2, e3, e4, e5);
    step();
    step();
    chk_lanes({tag, "_hold"}, e1, e2, e3, e4, e5);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    set_w(0, 0, 0, 0, 0);
    bus.mask_input = 1'b0;
    bus.load       = 1'b0;
    bus.accumulate = 1'b0;

    // Reset held with random activity on every input.
    for (int i = 0; i < 4; i++) begin
      set_w($urandom, $urandom, $urandom, $urandom, $urandom);
      bus.mask_input = 1'($urandom);
      bus.load       = 1'($urandom);
      bus.accumulate = 1'($urandom);
      step();
    end
    chk_lanes("rst", 0, 0, 0, 0, 0);
    chk("rst_sig", int'(bus.accumulate_signal), 0);

    // After release, sums stay 0 while accumulate is low even with load toggling.
    bus.accumulate = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_w($urandom, $urandom, $urandom, $urandom, $urandom);
      bus.mask_input = 1'b1;
      bus.load       = 1'($urandom);
      step();
    end
    chk_lanes("idle", 0, 0, 0, 0, 0);
    chk("idle_sig", int'(bus.accumulate_signal), 0);

    // Basic run: 4 cycles of 1,2,3,-1,-128.
    set_w(1, 2, 3, -1, -128);
    run("basic", 4, '1, 4, 8, 12, -4, -512);

    // Masking: pattern 1,0,1,1,0 (bit 0 first) with weight 5.
    set_w(5, 5, 5, 5, 5);
    run("mask", 5, 256'(5'b01101), 15, 15, 15, 15, 15);

    // Restart from 15: new run must not add on top of the old sum.
    set_w(7, 7, 7, 7, 7);
    run("restart", 2, '1, 14, 14, 14, 14, 14);

    // Back-to-back: accumulate drops for one cycle only, second run restarts at 0.
    set_w(1, 1, 1, 1, 1);
    bus.mask_input = 1'b1;
    bus.load       = 1'b1;
    bus.accumulate = 1'b1;
    step(); step(); step();
    bus.accumulate = 1'b0;
    step();
    set_w(2, -2, 3, -3, 4);
    bus.accumulate = 1'b1;
    step(); step();
    bus.accumulate = 1'b0;
    bus.load       = 1'b0;
    step(); step();
    chk_lanes("b2b", 4, -4, 6, -6, 8);

    // Full length: 256 adds at both extremes.
    set_w(127, 127, 127, 127, 127);
    run("full_pos", 256, '1, 32512, 32512, 32512, 32512, 32512);
    set_w(-128, -128, -128, -128, -128);
    run("full_neg", 256, '1, -32768, -32768, -32768, -32768, -32768);

    // Mid-run reset after 10 cycles clears outputs without waiting for an edge.
    set_w(9, 9, 9, 9, 9);
    bus.mask_input = 1'b1;
    bus.load       = 1'b1;
    bus.accumulate = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_nonzero", int'(bus.accumulate_1 != 0), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_lanes("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst_sig", int'(bus.accumulate_signal), 0);
    bus.accumulate = 1'b0;
    bus.load       = 1'b0;
    step();
    #2;
    reset = 1'b1;
    step();
    set_w(2, -3, 4, 5, -6);
    run("post_rst", 3, '1, 6, -9, 12, 15, -18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
